multicycle_chunk_adder: RTL and testbench
=========================================

// Module: multicycle_chunk_adder
// PURPOSE
//  Parametrised, multi-cycle unsigned adder with start/done handshake. Successor to the
//  combinational fivebitsadder: WIDTH-bit operands added CHUNK bits per clock, LSB chunk
//  first, carry registered between chunks. Short per-cycle carry chain for wide (32-bit+)
//  datapaths in the ALU/organisation labs; same sum/carryOut/a/b/carryIn semantics.
// PARAMETERS
//  WIDTH  32  operand/sum width in bits; must be an integer multiple of CHUNK
//  CHUNK   8  bits added per clock; 1 <= CHUNK <= WIDTH; STEPS = WIDTH/CHUNK
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      asynchronous, active-high reset
//  start     in   1      request; sampled only when busy=0
//  a         in   WIDTH  operand A, captured on accepted start
//  b         in   WIDTH  operand B, captured on accepted start
//  carryIn   in   1      carry into bit 0, captured on accepted start
//  busy      out  1      1 while chunks are being processed
//  done      out  1      one-cycle pulse: sum/carryOut valid
//  sum       out  WIDTH  registered result; held from done until next done
//  carryOut  out  1      carry out of bit WIDTH-1; held like sum
//  overflow  out  1      signed (two's-complement) overflow; see CONFIGURATION
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; busy, done, sum, carryOut, overflow, internal
//    operand/carry/chunk-counter registers all 0 immediately. Op in flight discarded.
//  - FSM: IDLE --start--> RUN --(STEPS chunks)--> DONE --1 cycle--> IDLE.
//    DONE with start=1 goes directly to RUN (back-to-back accepted; busy=0 in DONE).
//  - Accept at edge k (start=1, busy=0): latch a, b, carryIn; counter=0; busy=1 from k.
//  - Edges k+1..k+STEPS: chunk i = counter: {c,s} = a[i*CHUNK+:CHUNK] + b[i*CHUNK+:CHUNK]
//    + carryReg; s stored in internal result, c -> carryReg. Full carry propagation
//    between chunks (e.g. 0xFFFFFFFF+1 ripples through every chunk).
//  - Edge k+STEPS: busy=0, done=1; sum=internal result, carryOut=final carry.
//    Latency start-edge to done-high = STEPS cycles. done=0 one cycle later
//    unless a new op also completes there (impossible; STEPS>=1).
//  - sum/carryOut/overflow update only at done; never show partial results.
//  - start while busy=1: ignored, no effect on in-flight op or latched operands.
//  - a/b/carryIn may change freely after acceptance.
//  - Arithmetic is modulo 2^WIDTH; carryOut is the 2^WIDTH bit.
// CONFIGURATION
//  ADDER_OVERFLOW_EN defined: at done, overflow = carry into MSB XOR carryOut
//    (signed overflow of a+b+carryIn); held with sum.
//  ADDER_OVERFLOW_EN undefined: overflow tied 0 (no extra logic); all other behaviour
//    identical.
// TESTING  (default WIDTH=32, CHUNK=8 -> STEPS=4 unless stated)
//  1 a=0x0000000A b=0x0000000B cin=0 -> sum=0x00000015 carryOut=0; done 4 cycles after
//    start edge, busy high for exactly those 4 cycles.
//  2 a=0xFFFFFFFF b=0x00000001 cin=0 -> sum=0x00000000 carryOut=1 (cross-chunk ripple).
//  3 a=0x7FFFFFFF b=0x00000001 cin=0 -> sum=0x80000000 carryOut=0; overflow=1 with
//    ADDER_OVERFLOW_EN, overflow=0 without.
//  4 start a=1,b=1; start again 2 cycles later with a=5,b=5 -> second ignored,
//    sum=0x00000002; then back-to-back start in done cycle accepted, sum=0x0000000A.
//  5 reset pulsed 2 cycles into an op -> busy, done, sum, carryOut=0 at once, no done
//    pulse; fresh start a=3,b=4 -> sum=0x00000007 after 4 cycles.
//  6 WIDTH=5 CHUNK=1: a=01111 b=01010 cin=1 -> sum=11010 carryOut=0, done after 5 cycles.

Source files
------------

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle unsigned adder: WIDTH-bit operands summed CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow flag is built only when ADDER_OVERFLOW_EN is defined.
module multicycle_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut,
    output logic             overflow
);
    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [CHUNK-1:0] a_chunk [STEPS];
    logic [CHUNK-1:0] b_chunk [STEPS];
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;

    // Slice the latched operands into chunks so the active one is a plain array select.
    genvar gi;
    generate
        for (gi = 0; gi < STEPS; gi++) begin : g_chunk
            assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign chunk_sum  = {1'b0, a_chunk[cnt_q]} + {1'b0, b_chunk[cnt_q]}
                      + {{CHUNK{1'b0}}, carry_q};
    assign last_chunk = (cnt_q == CW'(STEPS - 1));

`ifdef ADDER_OVERFLOW_EN
    logic ov_q, ov_d;
    logic ov_chunk;

    // Carry into the MSB is recovered from the MSB's own sum bit and operand bits.
    assign ov_chunk = a_chunk[cnt_q][CHUNK-1] ^ b_chunk[cnt_q][CHUNK-1]
                    ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];

    always_comb begin
        ov_d = ov_q;
        if (state_q == S_RUN && last_chunk) begin
            ov_d = ov_chunk;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ov_q <= 1'b0;
        end else begin
            ov_q <= ov_d;
        end
    end

    assign overflow = ov_q;
`else
    assign overflow = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    carry_d = carryIn;
                    res_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int i = 0; i < STEPS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                carry_d = chunk_sum[CHUNK];
                if (last_chunk) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    sum_d   = res_d;
                    cout_d  = chunk_sum[CHUNK];
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign carryOut = cout_q;
endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Scoreboard bench for multicycle_chunk_adder: 32/8 instance plus a 5/1 instance.
// Overflow expectations follow ADDER_OVERFLOW_EN when the bench is built with it.
module tb_multicycle_chunk_adder;
`ifdef ADDER_OVERFLOW_EN
    localparam bit OV_EN = 1'b1;
`else
    localparam bit OV_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ov;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cin;
    logic [31:0] a, b;
    logic        busy, done, cout, ov;
    logic [31:0] sum;

    logic        start5, cin5;
    logic [4:0]  a5, b5;
    logic        busy5, done5, cout5, ov5;
    logic [4:0]  sum5;

    exp_t exp_q[$];
    exp_t exp5_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .carryIn(cin),
        .busy(busy), .done(done), .sum(sum), .carryOut(cout), .overflow(ov)
    );

    multicycle_chunk_adder #(.WIDTH(5), .CHUNK(1)) u_dut5 (
        .clk(clk), .reset(reset), .start(start5), .a(a5), .b(b5), .carryIn(cin5),
        .busy(busy5), .done(done5), .sum(sum5), .carryOut(cout5), .overflow(ov5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic compare_result(input exp_t e, input logic [31:0] s, input logic c,
                                  input logic o);
        check({e.name, " sum"}, s, e.sum);
        check({e.name, " carryOut"}, {31'b0, c}, {31'b0, e.cout});
        check({e.name, " overflow"}, {31'b0, o}, {31'b0, e.ov});
        check({e.name, " done cycle"}, 32'(cyc), 32'(e.cyc));
        $display("op %s: sum=%h carryOut=%0d overflow=%0d at cycle %0d", e.name, s, c, o, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected done (32/8)", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                compare_result(e, sum, cout, ov);
            end
        end
        if (done5) begin
            if (exp5_q.size() == 0) begin
                check("unexpected done (5/1)", 32'd1, 32'd0);
            end else begin
                e = exp5_q.pop_front();
                compare_result(e, {27'b0, sum5}, cout5, ov5);
            end
        end
    end

    // Called at a negedge; the op is accepted at the next posedge.
    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input string name);
        exp_t e;
        a = va; b = vb; cin = vc; start = 1'b1;
        e.sum = es; e.cout = ec; e.ov = OV_EN & eo; e.cyc = cyc + 1 + 4; e.name = name;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h5555_AAAA; cin = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({name, " done timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        exp_t e5;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset sum", sum, 32'd0);
        check("reset carryOut", {31'b0, cout}, 32'd0);
        check("reset overflow", {31'b0, ov}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Vector 1 with explicit busy/done timing.
        issue(32'h0000_000A, 32'h0000_000B, 1'b0, 32'h0000_0015, 1'b0, 1'b0, "t1 0A+0B");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1 busy cycle %0d", i), {31'b0, busy}, 32'd1);
            check($sformatf("t1 no done cycle %0d", i), {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        check("t1 busy low at done", {31'b0, busy}, 32'd0);
        check("t1 done high", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("t1 done one cycle", {31'b0, done}, 32'd0);

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "t2 ripple");
        wait_done("t2"); @(negedge clk);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "t3 ovf");
        wait_done("t3"); @(negedge clk);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1, "neg ovf cin");
        wait_done("neg"); @(negedge clk);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, "mixed");
        wait_done("mixed"); @(negedge clk);

        // Vector 4: start while busy is ignored, then back-to-back from the done cycle.
        issue(32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0, "t4 first");
        @(negedge clk);
        a = 32'h5; b = 32'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4 first");
        check("t4 busy low in done", {31'b0, busy}, 32'd0);
        issue(32'h5, 32'h5, 1'b0, 32'hA, 1'b0, 1'b0, "t4 back-to-back");
        check("t4 busy after b2b accept", {31'b0, busy}, 32'd1);
        wait_done("t4 b2b"); @(negedge clk);

        // Vector 5: reset mid-op clears everything immediately, no done for the aborted op.
        a = 32'h9; b = 32'h9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5 busy at reset", {31'b0, busy}, 32'd0);
        check("t5 done at reset", {31'b0, done}, 32'd0);
        check("t5 sum at reset", sum, 32'd0);
        check("t5 carryOut at reset", {31'b0, cout}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(32'h3, 32'h4, 1'b0, 32'h7, 1'b0, 1'b0, "t5 after reset");
        wait_done("t5"); @(negedge clk);

        // Vector 6 on the WIDTH=5 CHUNK=1 instance: 5-cycle latency.
        a5 = 5'b01111; b5 = 5'b01010; cin5 = 1'b1; start5 = 1'b1;
        e5.sum = 32'b11010; e5.cout = 1'b0; e5.ov = OV_EN; e5.cyc = cyc + 1 + 5;
        e5.name = "t6 w5c1";
        exp5_q.push_back(e5);
        @(negedge clk);
        start5 = 1'b0; a5 = 5'b10101; b5 = 5'b11111; cin5 = 1'b0;
        repeat (8) @(negedge clk);

        check("scoreboard 32/8 drained", 32'(exp_q.size()), 32'd0);
        check("scoreboard 5/1 drained", 32'(exp5_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
